// File: rtl/hamming_pkg.sv
// Shared constants and types for the extended-Hamming (16,11) SECDED serial link.
// Used by the transmit encoder, the codeword generator and decoder-side logic.
package hamming_pkg;

  localparam int BLK_LEN = 16;
  localparam int DATA_W  = 11;
  localparam int POS_W   = 4;

  typedef logic [POS_W-1:0]   pos_t;
  typedef logic [BLK_LEN-1:0] codeword_t;
  typedef logic [DATA_W-1:0]  data_t;

  // Data bits fill the non-power-of-two positions in ascending order.
  localparam pos_t DATA_POS [DATA_W] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

  // Check bits live at positions 1, 2, 4, 8 (bit k of the position index).
  localparam pos_t CHECK_POS [POS_W] = '{4'd1, 4'd2, 4'd4, 4'd8};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/hamming_cw_gen.sv
// Purely combinational data -> extended-Hamming (16,11) codeword generator.
// Position 0 holds overall parity so the XOR of all 16 bits is zero.
module hamming_cw_gen
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  output logic [BLK_LEN-1:0] codeword
);

  logic [BLK_LEN-1:0] placed;
  logic [POS_W-1:0]   checks;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
    placed = '0;
    for (int i = 0; i < DATA_W; i++) begin
      placed[DATA_POS[i]] = data[i];
    end
  end

  always_comb begin
    checks = '0;
    for (int k = 0; k < POS_W; k++) begin
      for (int p = 1; p < BLK_LEN; p++) begin
        if (((p >> k) & 1) == 1) begin
          checks[k] = checks[k] ^ placed[p];
        end
      end
    end
  end

  always_comb begin
    codeword = placed;
    for (int k = 0; k < POS_W; k++) begin
      codeword[CHECK_POS[k]] = checks[k];
    end
    codeword[0] = ^codeword[BLK_LEN-1:1];
  end

endmodule

// File: rtl/hamming_serial_encoder.sv
// Serial (16,11) SECDED encoder: accepts a word on valid/ready, shifts the codeword out LSB first.
// Optional ERR_INJECT_EN adds inj_mask[15:0], XORed into the codeword at accept time.
module hamming_serial_encoder
  import hamming_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                data_valid,
`ifdef ERR_INJECT_EN
  input  logic [BLK_LEN-1:0]  inj_mask,
`endif
  output logic                data_ready,
  output logic                bit_out,
  output logic                bit_valid,
  output logic                block_start
);

  localparam pos_t LAST_POS = pos_t'(BLK_LEN - 1);

  state_t             state;
  pos_t               cnt;
  logic [BLK_LEN-1:0] shreg;
  logic [BLK_LEN-1:0] cw;
  logic [BLK_LEN-1:0] cw_load;
  logic               accept;

  hamming_cw_gen u_cw_gen (
    .data     (data_in),
    .codeword (cw)
  );

`ifdef ERR_INJECT_EN
  assign cw_load = cw ^ inj_mask;
`else
  assign cw_load = cw;
`endif

  // Ready in IDLE or while the last bit is on the wire, giving gapless back-to-back blocks.
  assign data_ready = (state == S_IDLE) || (cnt == LAST_POS);
  assign accept     = data_valid && data_ready;

  // shreg[0] always mirrors the bit currently on bit_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register here, shift register included, is cleared so a reset mid-block leaves no stale bits.
      state       <= S_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      block_start <= 1'b0;
    end else if (accept) begin
      state       <= S_SEND;
      cnt         <= '0;
      shreg       <= cw_load;
      bit_out     <= cw_load[0];
      bit_valid   <= 1'b1;
      block_start <= 1'b1;
    end else if (state == S_SEND && cnt != LAST_POS) begin
      cnt         <= cnt + 1'b1;
      shreg       <= {1'b0, shreg[BLK_LEN-1:1]};
      bit_out     <= shreg[1];
      bit_valid   <= 1'b1;
      block_start <= 1'b0;
    end else begin
      state       <= S_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      block_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hamming_serial_encoder.sv
// Directed bench for hamming_serial_encoder: table of words with hand-derived codewords,
// back-to-back streaming, asynchronous reset mid-block, optional error injection.
module tb_hamming_serial_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic        bit_out;
  logic        bit_valid;
  logic        block_start;
`ifdef ERR_INJECT_EN
  logic [15:0] inj_mask = '0;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  hamming_serial_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .data_valid  (data_valid),
`ifdef ERR_INJECT_EN
    .inj_mask    (inj_mask),
`endif
    .data_ready  (data_ready),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .block_start (block_start)
  );

  typedef struct {
    logic [10:0] data;
    logic [15:0] cw;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Independent reference: place data at non-power-of-two slots, then fill checks and parity.
  function automatic logic [15:0] ref_cw(input logic [10:0] d);
    logic [15:0] c;
    int j;
    c = '0;
    j = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      for (int q = 3; q < 16; q++) begin
        if ((q & (q - 1)) != 0 && (q & p) != 0) c[p] = c[p] ^ c[q];
      end
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [4:0] decode_chk(input logic [15:0] c);
    logic [3:0] s;
    logic       par;
    s = '0;
    par = 1'b0;
    for (int p = 0; p < 16; p++) begin
      if (c[p]) s = s ^ 4'(p);
      par = par ^ c[p];
    end
    return {par, s};
  endfunction

  // Called at a sample point (#1 after posedge); returns with the encoder back in IDLE.
  task automatic run_block(input string name, input logic [10:0] d, input logic [15:0] exp,
                           output logic [15:0] got);
    int  n;
    bit  bv_ok;
    bit  bs_ok;
    got = '0;
    bv_ok = 1'b1;
    bs_ok = 1'b1;
    data_in = d;
    data_valid = 1'b1;
    n = 0;
    while (!data_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " ready_timeout"}, 32'(n < 40), 32'd1);
    @(posedge clk); #1;
    data_valid = 1'b0;
    for (int p = 0; p < 16; p++) begin
      got[p] = bit_out;
      if (!bit_valid) bv_ok = 1'b0;
      if (block_start !== (p == 0)) bs_ok = 1'b0;
      if (p < 15) begin
        @(posedge clk); #1;
      end
    end
    check({name, " codeword"}, 32'(got), 32'(exp));
    check({name, " bit_valid16"}, 32'(bv_ok), 32'd1);
    check({name, " block_start"}, 32'(bs_ok), 32'd1);
    @(posedge clk); #1;
    check({name, " idle_after"}, {29'd0, bit_valid, bit_out, data_ready}, 32'b001);
  endtask

  vec_t        vecs [6];
  logic [15:0] got;
  logic [10:0] words [3];
  logic [15:0] stream [3];

  initial begin
    vecs[0] = '{11'h000, 16'h0000};
    vecs[1] = '{11'h001, 16'h000F};
    vecs[2] = '{11'h7FF, 16'hFFFF};
    vecs[3] = '{11'h002, 16'h0033};
    vecs[4] = '{11'h004, 16'h0055};
    vecs[5] = '{11'h400, 16'h8117};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {28'd0, data_ready, bit_valid, bit_out, block_start}, 32'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", {29'd0, data_ready, bit_valid, block_start}, 32'b100);

    for (int i = 0; i < 6; i++) begin
      run_block($sformatf("vec%0d", i), vecs[i].data, vecs[i].cw, got);
    end

    // Three words with data_valid held high: 48 gapless bits.
    begin
      int  k;
      int  bv_cnt;
      bit  bs_ok;
      bit  rdy_ok;
      bit  acc;
      words[0] = 11'h5A3;
      words[1] = 11'h0F0;
      words[2] = 11'h3C5;
      stream[0] = '0;
      stream[1] = '0;
      stream[2] = '0;
      k = 0;
      bv_cnt = 0;
      bs_ok = 1'b1;
      rdy_ok = 1'b1;
      data_in = words[0];
      data_valid = 1'b1;
      for (int c = 0; c < 48; c++) begin
        acc = data_ready && data_valid;
        @(posedge clk); #1;
        if (acc) begin
          k++;
          if (k < 3) data_in = words[k];
          else data_valid = 1'b0;
        end
        stream[c / 16][c % 16] = bit_out;
        if (bit_valid) bv_cnt++;
        if (block_start !== ((c % 16) == 0)) bs_ok = 1'b0;
        if (data_ready !== ((c % 16) == 15)) rdy_ok = 1'b0;
      end
      check("b2b accepts", 32'(k), 32'd3);
      check("b2b bit_valid_count", 32'(bv_cnt), 32'd48);
      check("b2b block_start", 32'(bs_ok), 32'd1);
      check("b2b data_ready", 32'(rdy_ok), 32'd1);
      for (int b = 0; b < 3; b++) begin
        check($sformatf("b2b cw%0d", b), 32'(stream[b]), 32'(ref_cw(words[b])));
        check($sformatf("b2b loopback%0d", b), 32'(decode_chk(stream[b])), 32'd0);
      end
      @(posedge clk); #1;
      check("b2b idle_after", {30'd0, bit_valid, data_ready}, 32'b01);
    end

    // Asynchronous reset while position 7 is on the wire.
    data_in = 11'h7FF;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("pre_reset_p7", {30'd0, bit_valid, bit_out}, 32'b11);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {28'd0, data_ready, bit_valid, bit_out, block_start}, 32'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("no_resume", {30'd0, bit_valid, data_ready}, 32'b01);
    run_block("restart", 11'h001, 16'h000F, got);

`ifdef ERR_INJECT_EN
    inj_mask = 16'h0020;
    run_block("inject", 11'h001, 16'h002F, got);
    inj_mask = 16'h0000;
    check("inject decode", 32'(decode_chk(got)), 32'h15);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
